// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM (1-cycle read latency) between the
//   CPU data port and the VGA screen-fetch port. The CPU has fixed priority.
//   A pending screen read that has been blocked for MAX_WAIT cycles is forced
//   through on the next cycle. A saturating counter records the cycles the CPU
//   spent blocked, for the perf display.
//
// Ports
//   cpu_clk, reset                      clock; async active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt    CPU request, granted combinationally
//   cpu_rvalid, cpu_rdata               CPU read return, 1 cycle after grant
//   scr_req/addr -> scr_gnt             screen read request / grant
//   scr_rvalid, scr_rdata               screen read return, 1 cycle after grant
//   mem_en/we/addr/wdata, mem_rdata     single-port RAM interface
//   cpu_stall_cnt                       saturating count of CPU-blocked cycles
module ram_port_arbiter #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 12,
    parameter int MAX_WAIT        = 4,   // 1..15
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       cpu_clk,
    input  logic                       reset,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [ADDR_WIDTH-1:0]      cpu_addr,
    input  logic [DATA_WIDTH-1:0]      cpu_wdata,
    output logic                       cpu_gnt,
    output logic                       cpu_rvalid,
    output logic [DATA_WIDTH-1:0]      cpu_rdata,
    input  logic                       scr_req,
    input  logic [ADDR_WIDTH-1:0]      scr_addr,
    output logic                       scr_gnt,
    output logic                       scr_rvalid,
    output logic [DATA_WIDTH-1:0]      scr_rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic [STALL_CNT_WIDTH-1:0] cpu_stall_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        SCR_RD = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    owner_t                     r_owner;
    logic [3:0]                 r_wait_cnt;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    logic w_force;
    logic w_scr_gnt;
    logic w_cpu_gnt;

    // The screen wins only when the CPU is idle or the screen has waited
    // long enough; otherwise the CPU keeps its fixed priority.
    assign w_force   = scr_req && (r_wait_cnt == MAX_W);
    assign w_scr_gnt = scr_req && (!cpu_req || w_force);
    assign w_cpu_gnt = cpu_req && !w_scr_gnt;

    assign cpu_gnt   = w_cpu_gnt;
    assign scr_gnt   = w_scr_gnt;

    assign mem_en    = w_cpu_gnt | w_scr_gnt;
    assign mem_we    = w_cpu_gnt & cpu_we;
    assign mem_addr  = w_cpu_gnt ? cpu_addr :
                       w_scr_gnt ? scr_addr : '0;
    assign mem_wdata = w_cpu_gnt ? cpu_wdata : '0;

    // Both read ports see the RAM output directly; the owner register
    // remembers who issued last cycle's read and qualifies it.
    assign cpu_rvalid    = (r_owner == CPU_RD);
    assign scr_rvalid    = (r_owner == SCR_RD);
    assign cpu_rdata     = mem_rdata;
    assign scr_rdata     = mem_rdata;
    assign cpu_stall_cnt = r_stall_cnt;

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            r_owner     <= IDLE;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_cpu_gnt && !cpu_we)
                r_owner <= CPU_RD;
            else if (w_scr_gnt)
                r_owner <= SCR_RD;
            else
                r_owner <= IDLE;

            // A blocked screen request always gets the forced grant once the
            // count reaches MAX_W, so the hold branch only guards against an
            // out-of-range parameter.
            if (!scr_req || w_scr_gnt)
                r_wait_cnt <= '0;
            else if (r_wait_cnt != MAX_W)
                r_wait_cnt <= r_wait_cnt + 4'd1;

            if (cpu_req && !w_cpu_gnt && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int SW = 4;

    logic          cpu_clk;
    logic          reset;
    logic          cpu_req, cpu_we, scr_req;
    logic [AW-1:0] cpu_addr, scr_addr;
    logic [DW-1:0] cpu_wdata;

    // dut0: MAX_WAIT=4 with a RAM model; dut1: MAX_WAIT=1, grant/stall only
    logic          cpu_gnt, cpu_rvalid, scr_gnt, scr_rvalid;
    logic [DW-1:0] cpu_rdata, scr_rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] cpu_stall_cnt;

    logic          d1_cpu_gnt, d1_cpu_rvalid, d1_scr_gnt, d1_scr_rvalid;
    logic [DW-1:0] d1_cpu_rdata, d1_scr_rdata, d1_mem_wdata;
    logic          d1_mem_en, d1_mem_we;
    logic [AW-1:0] d1_mem_addr;
    logic [SW-1:0] d1_cpu_stall_cnt;
    logic [DW-1:0] d1_mem_rdata;

    assign d1_mem_rdata = '0;

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(4), .STALL_CNT_WIDTH(SW)) dut (
        .cpu_clk(cpu_clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .scr_req(scr_req), .scr_addr(scr_addr), .scr_gnt(scr_gnt),
        .scr_rvalid(scr_rvalid), .scr_rdata(scr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_stall_cnt(cpu_stall_cnt)
    );

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(1), .STALL_CNT_WIDTH(SW)) dut1 (
        .cpu_clk(cpu_clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(d1_cpu_gnt), .cpu_rvalid(d1_cpu_rvalid), .cpu_rdata(d1_cpu_rdata),
        .scr_req(scr_req), .scr_addr(scr_addr), .scr_gnt(d1_scr_gnt),
        .scr_rvalid(d1_scr_rvalid), .scr_rdata(d1_scr_rdata),
        .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .mem_rdata(d1_mem_rdata), .cpu_stall_cnt(d1_cpu_stall_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // Single-port synchronous RAM; filled with a known pattern on first edge.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          ram_ready = 1'b0;
    always @(posedge cpu_clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= 16'hA000 ^ 16'(i);
            ram_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] cpu_q[$];
    logic [DW-1:0] scr_q[$];
    logic          exp_crv, exp_srv;
    int            n_cmp, n_fail;

    typedef struct {
        logic          creq, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          sreq;
        logic [AW-1:0] saddr;
        logic          ecg, esg;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check on negedge, then advance.
    task automatic step(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                        input logic [DW-1:0] cwd, input logic sreq, input logic [AW-1:0] saddr,
                        input logic ecg, input logic esg,
                        input bit chk1, input logic e1cg, input logic e1sg, input string nm);
        logic [AW-1:0] ea;
        logic [DW-1:0] d;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        scr_req = sreq; scr_addr = saddr;
        @(negedge cpu_clk);
        ea = ecg ? caddr : (esg ? saddr : '0);
        chk({nm, " cpu_gnt"}, 32'(cpu_gnt), 32'(ecg));
        chk({nm, " scr_gnt"}, 32'(scr_gnt), 32'(esg));
        chk({nm, " mem_en"},  32'(mem_en),  32'(ecg | esg));
        chk({nm, " mem_we"},  32'(mem_we),  32'(ecg & cwe));
        chk({nm, " mem_addr"}, 32'(mem_addr), 32'(ea));
        if (ecg && cwe) chk({nm, " mem_wdata"}, 32'(mem_wdata), 32'(cwd));
        chk({nm, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(exp_crv));
        chk({nm, " scr_rvalid"}, 32'(scr_rvalid), 32'(exp_srv));
        if (exp_crv && cpu_q.size() > 0) begin
            d = cpu_q.pop_front();
            chk({nm, " cpu_rdata"}, 32'(cpu_rdata), 32'(d));
        end
        if (exp_srv && scr_q.size() > 0) begin
            d = scr_q.pop_front();
            chk({nm, " scr_rdata"}, 32'(scr_rdata), 32'(d));
        end
        if (chk1) begin
            chk({nm, " d1 cpu_gnt"}, 32'(d1_cpu_gnt), 32'(e1cg));
            chk({nm, " d1 scr_gnt"}, 32'(d1_scr_gnt), 32'(e1sg));
        end
        exp_crv = ecg && !cwe;
        exp_srv = esg;
        if (ecg && !cwe) cpu_q.push_back(shadow[caddr]);
        if (ecg && cwe)  shadow[caddr] = cwd;
        if (esg)         scr_q.push_back(shadow[saddr]);
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; scr_req = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; scr_addr = '0;
        @(negedge cpu_clk);
        chk({nm, " rst cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({nm, " rst scr_rvalid"}, 32'(scr_rvalid), 32'd0);
        chk({nm, " rst stall"},      32'(cpu_stall_cnt), 32'd0);
        chk({nm, " rst d1 stall"},   32'(d1_cpu_stall_cnt), 32'd0);
        chk({nm, " rst mem_en"},     32'(mem_en), 32'd0);
        @(posedge cpu_clk);
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        exp_crv = 1'b0; exp_srv = 1'b0;
        cpu_q.delete(); scr_q.delete();
    endtask

    task automatic idle(input string nm);
        step(0, 0, '0, '0, 0, '0, 0, 0, 0, 0, 0, nm);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        exp_crv = 1'b0; exp_srv = 1'b0;
        for (int i = 0; i < (1 << AW); i++) shadow[i] = 16'hA000 ^ 16'(i);

        //          creq cwe caddr     cwd       sreq saddr    ecg esg
        tbl[0]  = '{0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0};
        tbl[1]  = '{1, 1, 12'h010, 16'hBEEF, 0, 12'h000, 1, 0};
        tbl[2]  = '{1, 0, 12'h010, 16'h0000, 0, 12'h000, 1, 0};
        tbl[3]  = '{0, 1, 12'h011, 16'h1111, 0, 12'h000, 0, 0};
        tbl[4]  = '{0, 0, 12'h000, 16'h0000, 1, 12'h000, 0, 1};
        tbl[5]  = '{0, 0, 12'h000, 16'h0000, 1, 12'h001, 0, 1};
        tbl[6]  = '{0, 0, 12'h000, 16'h0000, 1, 12'h002, 0, 1};
        tbl[7]  = '{0, 0, 12'h000, 16'h0000, 1, 12'h003, 0, 1};
        tbl[8]  = '{1, 0, 12'h003, 16'h0000, 1, 12'h004, 1, 0};
        tbl[9]  = '{0, 0, 12'h000, 16'h0000, 1, 12'h004, 0, 1};
        tbl[10] = '{1, 1, 12'h0FF, 16'h5A5A, 1, 12'h005, 1, 0};
        tbl[11] = '{1, 0, 12'h0FF, 16'h0000, 1, 12'h005, 1, 0};
        tbl[12] = '{0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0};
        tbl[13] = '{1, 0, 12'hFFF, 16'h0000, 0, 12'h000, 1, 0};
        tbl[14] = '{0, 0, 12'h000, 16'h0000, 0, 12'h000, 0, 0};

        do_reset("init");
        for (int i = 0; i < 15; i++)
            step(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].cwd, tbl[i].sreq, tbl[i].saddr,
                 tbl[i].ecg, tbl[i].esg, 0, 0, 0, $sformatf("vec%0d", i));

        // Continuous contention: 4 CPU then 1 screen (MAX_WAIT=4); alternate (MAX_WAIT=1).
        do_reset("cont");
        for (int k = 0; k < 20; k++)
            step(1, 0, 12'h010, '0, 1, 12'h003, (k % 5) != 4, (k % 5) == 4,
                 1, (k % 2) == 0, (k % 2) == 1, $sformatf("cont%0d", k));
        idle("cont drain");
        chk("cont stall", 32'(cpu_stall_cnt), 32'd4);
        chk("cont d1 stall", 32'(d1_cpu_stall_cnt), 32'd10);

        // Forced screen grant lands on a CPU write; the write follows next cycle.
        do_reset("force");
        for (int k = 0; k < 4; k++)
            step(1, 0, 12'h010, '0, 1, 12'h006, 1, 0, 0, 0, 0, $sformatf("force rd%0d", k));
        step(1, 1, 12'h020, 16'h1234, 1, 12'h006, 0, 1, 0, 0, 0, "force blocked wr");
        step(1, 1, 12'h020, 16'h1234, 0, 12'h000, 1, 0, 0, 0, 0, "force late wr");
        step(1, 0, 12'h020, '0,       0, 12'h000, 1, 0, 0, 0, 0, "force rd back");
        idle("force drain");

        // Reset with a read outstanding and a partially counted wait.
        for (int k = 0; k < 3; k++)
            step(1, 0, 12'h030, '0, 1, 12'h007, 1, 0, 0, 0, 0, $sformatf("rstrd%0d", k));
        do_reset("midread");
        idle("post rst");
        for (int k = 0; k < 5; k++)
            step(1, 0, 12'h030, '0, 1, 12'h007, k != 4, k == 4, 0, 0, 0, $sformatf("post rst%0d", k));
        idle("post rst drain");

        // Stall counter saturation (dut1 blocks the CPU every other cycle).
        do_reset("sat");
        for (int k = 0; k < 40; k++) begin
            step(1, 0, 12'h040, '0, 1, 12'h008, (k % 5) != 4, (k % 5) == 4,
                 1, (k % 2) == 0, (k % 2) == 1, $sformatf("sat%0d", k));
            if (k == 9) chk("sat d1 stall mid", 32'(d1_cpu_stall_cnt), 32'd5);
        end
        idle("sat drain");
        chk("sat d1 stall", 32'(d1_cpu_stall_cnt), 32'hF);
        chk("sat stall", 32'(cpu_stall_cnt), 32'd8);
        chk("cpu queue empty", 32'(cpu_q.size()), 32'd0);
        chk("scr queue empty", 32'(scr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one single-port synchronous data RAM (1-cycle read latency) between two requesters: the CPU data port and the VGA screen-fetch port. The CPU has fixed priority. An anti-starvation wait counter forces a screen grant after MAX_WAIT blocked cycles. The block sits between cpu/vga and a single-port ram instance, replacing the dual-port screen read path, and exports a CPU stall statistic for the perf display.

Parameters:
DATA_WIDTH, 16, RAM word width.
ADDR_WIDTH, 12, RAM address width (2**12 words).
MAX_WAIT, 4, max consecutive cycles a pending screen request may be blocked; legal range 1..15.
STALL_CNT_WIDTH, 16, width of the saturating CPU stall counter.

Ports:
cpu_clk  in  1  sole clock; all state on rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_gnt.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_WIDTH  CPU word address.
cpu_wdata  in  DATA_WIDTH  CPU write data.
cpu_gnt  out  1  CPU access issued to RAM this cycle.
cpu_rvalid  out  1  cpu_rdata valid this cycle.
cpu_rdata  out  DATA_WIDTH  CPU read data.
scr_req  in  1  screen read request; held with scr_addr stable until scr_gnt.
scr_addr  in  ADDR_WIDTH  screen word address.
scr_gnt  out  1  screen read issued to RAM this cycle.
scr_rvalid  out  1  scr_rdata valid this cycle.
scr_rdata  out  DATA_WIDTH  screen read data.
mem_en  out  1  RAM access enable.
mem_we  out  1  RAM write enable.
mem_addr  out  ADDR_WIDTH  RAM address.
mem_wdata  out  DATA_WIDTH  RAM write data.
mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read is issued.
cpu_stall_cnt  out  STALL_CNT_WIDTH  cycles the CPU was blocked by the screen; saturating.

Behaviour:
- Reset values: wait_cnt=0, owner=IDLE, cpu_stall_cnt=0, cpu_rvalid=0, scr_rvalid=0. Grants are combinational but are 0 whenever the corresponding req is 0.
- Grant logic (combinational from req inputs and registered wait_cnt):
  - force = scr_req && (wait_cnt == MAX_WAIT).
  - scr_gnt = scr_req && (!cpu_req || force).
  - cpu_gnt = cpu_req && !scr_gnt.
  - At most one grant per cycle. Simultaneous requests go to the CPU unless force is set.
- RAM drive:
  - mem_en = cpu_gnt | scr_gnt.
  - mem_we = cpu_gnt & cpu_we. The screen never writes.
  - mem_addr and mem_wdata come from the granted requester. When idle they are 0.
- wait_cnt:
  - Cleared when scr_req=0 or scr_gnt=1.
  - Otherwise incremented (scr_req && !scr_gnt). It never exceeds MAX_WAIT.
- owner register, next value:
  - CPU_RD if cpu_gnt && !cpu_we.
  - SCR_RD if scr_gnt.
  - IDLE otherwise (including CPU write).
- Read return:
  - cpu_rvalid = (owner==CPU_RD); scr_rvalid = (owner==SCR_RD). Latency is exactly 1 cycle after grant.
  - Both rdata outputs drive mem_rdata directly and are meaningful only while their rvalid is high.
  - Back-to-back grants give back-to-back rvalids with no bubble.
- cpu_stall_cnt:
  - Increments each cycle with cpu_req && !cpu_gnt.
  - Holds at 2**STALL_CNT_WIDTH-1, no wrap.
- Boundary conditions:
  - Forced screen grant on a CPU write cycle: the write is blocked and issued the next cycle (wait_cnt is now 0). The write is not lost.
  - Requester deasserts req before gnt: protocol violation; the arbiter needs no recovery logic.
  - Reset asserted with a read outstanding: the read is dropped and no rvalid is produced after reset release. The RAM contents are unaffected by the arbiter.
  - MAX_WAIT=1: under continuous contention, grants alternate CPU, SCR, CPU, SCR...

Test Plan:
- Reset, then CPU write addr 0x010 data 0xBEEF, then CPU read 0x010. Required: cpu_gnt both cycles, mem_we=1 on the first only, cpu_rvalid=1 with cpu_rdata=0xBEEF exactly 1 cycle after the read grant.
- Screen-only reads of 0x000..0x003 on consecutive cycles. Required: scr_gnt every cycle, scr_rvalid on 4 consecutive cycles starting 1 cycle after the first grant, data in address order.
- MAX_WAIT=4, cpu_req and scr_req held high for 20 cycles. Required: pattern of 4 CPU grants then 1 screen grant, repeating; cpu_stall_cnt=4 at the end.
- Forced screen grant coinciding with a CPU write of 0x1234 to 0x020. Required: the write lands the following cycle; a later read of 0x020 returns 0x1234.
- Assert reset one cycle after a CPU read grant. Required: cpu_rvalid stays 0; wait_cnt and cpu_stall_cnt read 0; normal operation resumes after release.
- STALL_CNT_WIDTH=4, CPU blocked for 20 cycles. Required: cpu_stall_cnt saturates at 0xF.
